// File: rtl/cpu1_oci_trace_pkg.sv
// Shared constants and types for the CPU1 OCI instruction-trace front end.
package cpu1_oci_trace_pkg;

    localparam int unsigned CODE_W      = 2;
    localparam int unsigned DCT_ENTRIES = 15;
    localparam int unsigned OVF_W       = 8;
    localparam int unsigned BUF_W       = CODE_W * DCT_ENTRIES;
    localparam int unsigned CNT_W       = $clog2(DCT_ENTRIES + 1);

    // DCT code points; reserved is packed unchanged like any other code
    localparam logic [CODE_W-1:0] DCT_RSVD   = 2'b00;
    localparam logic [CODE_W-1:0] DCT_TAKEN  = 2'b01;
    localparam logic [CODE_W-1:0] DCT_NTAKEN = 2'b10;
    localparam logic [CODE_W-1:0] DCT_XRET   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DCT_ENTRIES);

    typedef enum logic {
        ST_FILL,
        ST_STALL
    } pack_state_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [BUF_W-1:0] data;
    } dct_frame_t;

endpackage

// File: rtl/cpu1_oci_dct_frame_reg.sv
// One-entry valid/ready frame holding register; a reload on the draining cycle keeps valid high.
module cpu1_oci_dct_frame_reg
    import cpu1_oci_trace_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  dct_frame_t frame_i,
    input  logic       ready_i,
    output logic       valid_o,
    output dct_frame_t frame_o,
    output logic       free_c
);

    logic       valid_q;
    dct_frame_t frame_q;

    assign free_c  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign frame_o = frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            frame_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            frame_q <= frame_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu1_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into a 15-entry buffer and hands full/flushed buffers out as frames.
module cpu1_oci_dct_packer
    import cpu1_oci_trace_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trace_en,
    input  logic              dct_valid,
    input  logic [CODE_W-1:0] dct_code,
    input  logic              flush,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [BUF_W-1:0]  frm_data,
    output logic [CNT_W-1:0]  frm_count,
    input  logic              ovf_clr,
    output logic [OVF_W-1:0]  ovf_cnt
);

    pack_state_e      state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             pend_q, pend_d;
    logic             trace_en_q;
    logic             accept, drop, eff_flush, pack, load, slot_free;
    dct_frame_t       frame_in, frame_out;

    cpu1_oci_dct_frame_reg u_frame_reg (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (load),
        .frame_i (frame_in),
        .ready_i (frm_ready),
        .valid_o (frm_valid),
        .frame_o (frame_out),
        .free_c  (slot_free)
    );

    assign frm_data   = frame_out.data;
    assign frm_count  = frame_out.count;
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign ovf_cnt    = ovf_q;

    // Append first, then decide whether the updated buffer is packed this cycle
    always_comb begin
        accept    = dct_valid && trace_en && (cnt_q != CNT_FULL);
        drop      = dct_valid && trace_en && (state_q == ST_STALL) && (cnt_q == CNT_FULL);
        buf_nx    = accept ? {buf_q[BUF_W-CODE_W-1:0], dct_code} : buf_q;
        cnt_nx    = accept ? cnt_q + CNT_W'(1) : cnt_q;
        eff_flush = flush || (trace_en_q && !trace_en) || pend_q;
        pack      = (cnt_nx == CNT_FULL) || (eff_flush && (cnt_nx != '0));

        buf_d          = buf_nx;
        cnt_d          = cnt_nx;
        pend_d         = pend_q;
        load           = 1'b0;
        frame_in.data  = buf_nx;
        frame_in.count = cnt_nx;

        if (pack && slot_free) begin
            load   = 1'b1;
            buf_d  = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (pack) begin
            // Slot busy: hold the contents and remember a flush so it is retried
            if (eff_flush) pend_d = 1'b1;
        end else if (eff_flush) begin
            pend_d = 1'b0;
        end

        if (ovf_clr)                      ovf_d = drop ? OVF_W'(1) : '0;
        else if (drop && (ovf_q != '1))   ovf_d = ovf_q + OVF_W'(1);
        else                              ovf_d = ovf_q;

        state_d = ((cnt_d == CNT_FULL) || pend_d) ? ST_STALL : ST_FILL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            buf_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            pend_q     <= 1'b0;
            trace_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            trace_en_q <= trace_en;
        end
    end

endmodule

// File: tb/tb_cpu1_oci_dct_packer.sv
// Directed bench for cpu1_oci_dct_packer with hand-computed expected frames.
module tb_cpu1_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_en, dct_valid, flush, frm_ready, ovf_clr;
    logic [1:0]  dct_code;
    logic [29:0] dct_buffer, frm_data;
    logic [3:0]  dct_count, frm_count;
    logic        frm_valid;
    logic [7:0]  ovf_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu1_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trace_en   (trace_en),
        .dct_valid  (dct_valid),
        .dct_code   (dct_code),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_data   (frm_data),
        .frm_count  (frm_count),
        .ovf_clr    (ovf_clr),
        .ovf_cnt    (ovf_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] code, input int n);
        dct_valid = 1'b1;
        dct_code  = code;
        for (int i = 0; i < n; i++) step();
        dct_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trace_en = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
        flush = 1'b0; frm_ready = 1'b1; ovf_clr = 1'b0;
        #1;
        tests++; if (dct_buffer !== 30'h0) begin fails++; $display("FAIL reset_buffer got %h want 0", dct_buffer); end
        tests++; if (dct_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", dct_count); end
        tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL reset_frm_valid got %b want 0", frm_valid); end
        tests++; if (frm_data !== 30'h0 || frm_count !== 4'd0) begin fails++; $display("FAIL reset_frame got %h/%0d want 0/0", frm_data, frm_count); end
        tests++; if (ovf_cnt !== 8'd0) begin fails++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_full_frame();
        trace_en = 1'b1; frm_ready = 1'b1;
        push(2'b01, 14);
        tests++; if (dct_count !== 4'd14 || frm_valid !== 1'b0) begin fails++; $display("FAIL fill14 got cnt %0d vld %b want 14/0", dct_count, frm_valid); end
        push(2'b01, 1);
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h15555555 || frm_count !== 4'd15) begin fails++; $display("FAIL full_frame got %b %h %0d want 1 15555555 15", frm_valid, frm_data, frm_count); end
        tests++; if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin fails++; $display("FAIL full_clear got %0d %h want 0 0", dct_count, dct_buffer); end
        step();
        tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL full_drain got %b want 0", frm_valid); end
    endtask

    task automatic test_flush();
        push(2'b01, 1); push(2'b10, 1); push(2'b11, 1);
        tests++; if (dct_buffer !== 30'h1B || dct_count !== 4'd3) begin fails++; $display("FAIL flush_pre got %h %0d want 1b 3", dct_buffer, dct_count); end
        flush = 1'b1; step(); flush = 1'b0;
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h1B || frm_count !== 4'd3) begin fails++; $display("FAIL flush_frame got %b %h %0d want 1 1b 3", frm_valid, frm_data, frm_count); end
        step();
    endtask

    task automatic test_same_cycle();
        flush = 1'b1; push(2'b10, 1);
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h2 || frm_count !== 4'd1) begin fails++; $display("FAIL same_cycle got %b %h %0d want 1 2 1", frm_valid, frm_data, frm_count); end
        step(); flush = 1'b0;
        tests++; if (frm_valid !== 1'b0 || dct_count !== 4'd0) begin fails++; $display("FAIL empty_flush got vld %b cnt %0d want 0 0", frm_valid, dct_count); end
        step();
    endtask

    task automatic test_overflow();
        frm_ready = 1'b0;
        push(2'b01, 15);
        push(2'b11, 15);
        tests++; if (dct_count !== 4'd15 || dct_buffer !== 30'h3FFFFFFF) begin fails++; $display("FAIL stall_buf got %0d %h want 15 3fffffff", dct_count, dct_buffer); end
        push(2'b10, 4);
        tests++; if (ovf_cnt !== 8'd4) begin fails++; $display("FAIL ovf4 got %0d want 4", ovf_cnt); end
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h15555555 || frm_count !== 4'd15) begin fails++; $display("FAIL held_frame got %b %h %0d want 1 15555555 15", frm_valid, frm_data, frm_count); end
        ovf_clr = 1'b1; push(2'b10, 1);
        tests++; if (ovf_cnt !== 8'd1) begin fails++; $display("FAIL clr_drop got %0d want 1", ovf_cnt); end
        step(); ovf_clr = 1'b0;
        tests++; if (ovf_cnt !== 8'd0) begin fails++; $display("FAIL clr got %0d want 0", ovf_cnt); end
        frm_ready = 1'b1; step();
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h3FFFFFFF || frm_count !== 4'd15 || dct_count !== 4'd0) begin fails++; $display("FAIL frame2 got %b %h %0d cnt %0d want 1 3fffffff 15 0", frm_valid, frm_data, frm_count, dct_count); end
        step();
        tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL frame2_drain got %b want 0", frm_valid); end
    endtask

    task automatic test_flush_pend();
        frm_ready = 1'b0;
        push(2'b10, 15);
        push(2'b01, 5);
        flush = 1'b1; step(); flush = 1'b0;
        tests++; if (dct_count !== 4'd5 || dct_buffer !== 30'h155) begin fails++; $display("FAIL pend_keep got %0d %h want 5 155", dct_count, dct_buffer); end
        tests++; if (frm_data !== 30'h2AAAAAAA || frm_count !== 4'd15) begin fails++; $display("FAIL pend_stable got %h %0d want 2aaaaaaa 15", frm_data, frm_count); end
        push(2'b11, 1);
        tests++; if (dct_count !== 4'd6 || dct_buffer !== 30'h557) begin fails++; $display("FAIL stall_append got %0d %h want 6 557", dct_count, dct_buffer); end
        frm_ready = 1'b1; step();
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h557 || frm_count !== 4'd6 || dct_count !== 4'd0) begin fails++; $display("FAIL pend_frame got %b %h %0d cnt %0d want 1 557 6 0", frm_valid, frm_data, frm_count, dct_count); end
        step();
        tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL pend_cleared got %b want 0", frm_valid); end
    endtask

    task automatic test_trace_stop();
        push(2'b01, 7);
        trace_en = 1'b0; step();
        tests++; if (frm_valid !== 1'b1 || frm_data !== 30'h1555 || frm_count !== 4'd7) begin fails++; $display("FAIL trace_stop got %b %h %0d want 1 1555 7", frm_valid, frm_data, frm_count); end
        push(2'b11, 2);
        tests++; if (dct_count !== 4'd0 || frm_valid !== 1'b0) begin fails++; $display("FAIL trace_off got cnt %0d vld %b want 0 0", dct_count, frm_valid); end
    endtask

    task automatic test_reset_mid_stall();
        trace_en = 1'b1; frm_ready = 1'b0;
        push(2'b01, 15);
        push(2'b10, 17);
        tests++; if (ovf_cnt !== 8'd2 || dct_count !== 4'd15) begin fails++; $display("FAIL pre_reset got ovf %0d cnt %0d want 2 15", ovf_cnt, dct_count); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (dct_buffer !== 30'h0 || dct_count !== 4'd0 || frm_valid !== 1'b0 || frm_data !== 30'h0 || frm_count !== 4'd0 || ovf_cnt !== 8'd0) begin fails++; $display("FAIL async_reset got %h %0d %b %h %0d %0d want all 0", dct_buffer, dct_count, frm_valid, frm_data, frm_count, ovf_cnt); end
        step();
        reset_n = 1'b1; frm_ready = 1'b1;
        step(); step();
        tests++; if (frm_valid !== 1'b0 || dct_count !== 4'd0) begin fails++; $display("FAIL post_reset got vld %b cnt %0d want 0 0", frm_valid, dct_count); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_same_cycle();
        test_overflow();
        test_flush_pend();
        test_trace_stop();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu1_oci_dct_packer.md
# cpu1_oci_dct_packer

Instruction-trace front end of the CPU1 on-chip instrumentation (OCI) path. Packs 2-bit direct-control-transfer (DCT) codes from the trace-event decoder into a 30-bit, 15-entry accumulation buffer. Hands completed or flushed buffers downstream as frames over a valid/ready handshake. Its live `dct_buffer`/`dct_count` outputs drive the OCI test bench and trace monitors directly.

## Interface
- `CODE_W`, 2, width of one DCT code
- `DCT_ENTRIES`, 15, codes per buffer (buffer width = `CODE_W*DCT_ENTRIES` = 30)
- `OVF_W`, 8, width of dropped-code counter
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `trace_en`  in  1  trace capture enable
- `dct_valid`  in  1  one DCT code presented this cycle
- `dct_code`  in  2  code: 01 taken, 10 not-taken, 11 exception-return, 00 reserved (packed as-is)
- `flush`  in  1  close current buffer (indirect jump, exception, trace stop)
- `dct_buffer`  out  30  live accumulation buffer
- `dct_count`  out  4  valid codes in `dct_buffer`, 0..15
- `frm_valid`  out  1  frame register holds a frame
- `frm_ready`  in  1  downstream accepts frame
- `frm_data`  out  30  frame payload
- `frm_count`  out  4  codes in frame, 1..15
- `ovf_clr`  in  1  clear `ovf_cnt`
- `ovf_cnt`  out  8  dropped codes, saturating at 255

## Operation
- Accept = `dct_valid & trace_en & (dct_count != 15)`; `dct_valid` ignored while `trace_en`=0.
- Append: buf_next = {buf[27:0], code}, count_next = count+1. Oldest code sits highest; unused high bits are 0.
- Effective flush = `flush`, or falling edge of `trace_en`, or a pending flush (`flush_pend`).
- Pack when count_next==15, or effective flush with count_next>0. Flush with count_next==0 produces no frame and clears `flush_pend`.
- Slot free = `!frm_valid | frm_ready`.
- Pack with slot free: `frm_data`<=buf_next, `frm_count`<=count_next, `frm_valid`<=1; `dct_buffer`<=0, `dct_count`<=0; clear `flush_pend`.
- Pack with slot busy: `dct_buffer`/`dct_count` take buf_next/count_next. If the pack was flush-caused, set `flush_pend`. Retry every cycle until the slot is free.
- States:
  - FILL: count<15, no `flush_pend`.
  - STALL: count==15, or `flush_pend`=1. While STALL with count<15, further codes still append. Reaching 15 keeps the stall.
- In STALL with count==15: every code that would otherwise be accepted increments `ovf_cnt`, saturating. The code is discarded.
- Frame register clears `frm_valid` on `frm_ready` unless reloaded the same cycle. `frm_data`/`frm_count` stay stable while `frm_valid & !frm_ready`.
- `ovf_clr` zeroes `ovf_cnt`. If `ovf_clr` and a drop occur in the same cycle, `ovf_cnt`=1.

## Timing
- All outputs registered. Reset values: `dct_buffer`=0, `dct_count`=0, `frm_valid`=0, `frm_data`=0, `frm_count`=0, `ovf_cnt`=0. Internal: `flush_pend`=0, `trace_en` history=0.
- Code accepted at edge N appears in `dct_buffer` after edge N.
- Frame appears on `frm_*` one edge after the packing cycle. Back-to-back frames are possible every cycle while `frm_ready`=1.
- Simultaneous `dct_valid` and `flush`: the code is appended first, then the buffer is packed (frame includes it).
- Simultaneous pack and downstream `frm_ready`: reload wins and `frm_valid` stays 1.
- Reset assertion mid-frame or mid-stall drops all contents immediately (asynchronous). No frame is emitted after release.

## Structure
- Package `cpu1_oci_trace_pkg`: `CODE_W`, `DCT_ENTRIES`, DCT code localparams, buffer-width constant.
- One sub-module: `cpu1_oci_dct_frame_reg`, a one-entry valid/ready holding register with the reload-on-drain rule.
- Packer FSM, `flush_pend`, and the overflow counter stay in the top module.

## Test plan
- Reset, then 15 accepted codes of 01 with `frm_ready`=1 -> one frame: `frm_data`=0x15555555, `frm_count`=15; `dct_count`=0 after the 15th edge.
- 3 codes 01,10,11 then `flush` -> `frm_data`=0x0000001B, `frm_count`=3.
- `dct_valid`(10) and `flush` in the same cycle with count 0 -> `frm_data`=0x2, `frm_count`=1. `flush` alone with count 0 -> no frame.
- `frm_ready`=0: fill 15 (frame 1 held), fill 15 more (STALL), 4 more codes -> `ovf_cnt`=4. Raise `frm_ready` -> frame 2 emitted the next cycle, `dct_count`=0.
- `frm_ready`=0, frame held, 5 codes then `flush` -> `flush_pend` set, buffer keeps 5. Raise `frm_ready` -> frame `frm_count`=5.
- Drop `trace_en` with 7 codes buffered -> frame `frm_count`=7. Assert `reset_n`=0 mid-stall -> all outputs 0 asynchronously.
